// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants and colour type
// for the NES video output path.
package vga_timing_pkg;
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int H_OFFSET = 64;
    localparam int NES_COLS = 256;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;

    localparam logic SYNC_ACTIVE = 1'b0;

    typedef logic [8:0] rgb9_t;
endpackage

// File: rtl/vga_timing_counter.sv
// Horizontal/vertical scan counters with raw sync
// and NES-window decodes.
module vga_timing_counter #(
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP     = vga_timing_pkg::H_FP,
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BP     = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP     = vga_timing_pkg::V_FP,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BP     = vga_timing_pkg::V_BP
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    output logic [9:0] h_o,
    output logic [9:0] v_o,
    output logic       win_o,
    output logic       hs_o,
    output logic       vs_o
);
    import vga_timing_pkg::*;

    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] W_FIRST  = 10'(H_OFFSET);
    localparam logic [9:0] W_LAST   = 10'(H_OFFSET + 2 * NES_COLS - 1);

    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;

    always_comb begin
        h_d = h_q + 10'd1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_o   = h_q;
    assign v_o   = v_q;
    assign win_o = (v_q < V_VIS) && (h_q >= W_FIRST) && (h_q <= W_LAST);
    assign hs_o  = ((h_q >= HS_FIRST) && (h_q <= HS_LAST)) ? SYNC_ACTIVE : !SYNC_ACTIVE;
    assign vs_o  = ((v_q >= VS_FIRST) && (v_q <= VS_LAST)) ? SYNC_ACTIVE : !SYNC_ACTIVE;
endmodule

// File: rtl/vga_out.sv
// VGA pixel output stage: 2x-scaled, centred NES picture with
// scanline-buffer fetch decode and a 2-clock aligned pin pipeline.
module vga_out #(
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP     = vga_timing_pkg::H_FP,
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BP     = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP     = vga_timing_pkg::V_FP,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BP     = vga_timing_pkg::V_BP
) (
    input  logic       pix_clk,
    input  logic       reset,
    input  logic [8:0] rgb_buf,
    output logic [7:0] pix_ptr_x,
    output logic [7:0] pix_ptr_y,
    output logic       reading,
    output logic [8:0] rgb,
    output logic       hsync,
    output logic       vsync
);
    import vga_timing_pkg::*;

    localparam logic [9:0] V_VIS = 10'(V_ACTIVE);
    localparam logic [9:0] H_OFF = 10'(H_OFFSET);

    logic [9:0] h, v, hoff;
    logic       win, hs_raw, vs_raw;

    vga_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_cnt (
        .clk_i  (pix_clk),
        .rst_ni (reset),
        .h_o    (h),
        .v_o    (v),
        .win_o  (win),
        .hs_o   (hs_raw),
        .vs_o   (vs_raw)
    );

    // Even lines fetch every other clock; odd lines replay the buffer.
    assign hoff      = h - H_OFF;
    assign pix_ptr_x = win ? 8'(hoff >> 1) : 8'd0;
    assign pix_ptr_y = (v < V_VIS) ? 8'(v >> 1) : 8'd0;
    assign reading   = win && !v[0] && !hoff[0];

    logic  win_dly_q, hs_dly_q, vs_dly_q;
    rgb9_t rgb_q, rgb_d;
    logic  hsync_q, vsync_q;

    assign rgb_d = win_dly_q ? rgb9_t'(rgb_buf) : '0;

    always_ff @(posedge pix_clk or negedge reset) begin
        if (!reset) begin
            win_dly_q <= 1'b0;
            hs_dly_q  <= !SYNC_ACTIVE;
            vs_dly_q  <= !SYNC_ACTIVE;
            rgb_q     <= '0;
            hsync_q   <= !SYNC_ACTIVE;
            vsync_q   <= !SYNC_ACTIVE;
        end else begin
            win_dly_q <= win;
            hs_dly_q  <= hs_raw;
            vs_dly_q  <= vs_raw;
            rgb_q     <= rgb_d;
            hsync_q   <= hs_dly_q;
            vsync_q   <= vs_dly_q;
        end
    end

    assign rgb   = rgb_q;
    assign hsync = hsync_q;
    assign vsync = vsync_q;
endmodule

// File: tb/tb_vga_out.sv
// Scoreboard bench for vga_out with a shortened vertical frame
// so a whole frame and its wrap fit in a short run.
module tb_vga_out;
    localparam int VA  = 12;
    localparam int VFP = 2;
    localparam int VSW = 2;
    localparam int VBP = 2;
    localparam int VT  = VA + VFP + VSW + VBP;
    localparam int VSS = VA + VFP;
    localparam int VSE = VSS + VSW - 1;
    localparam int HT  = 800;

    logic       pix_clk = 1'b0;
    logic       reset;
    logic [8:0] rgb_buf;
    logic [7:0] pix_ptr_x, pix_ptr_y;
    logic       reading;
    logic [8:0] rgb;
    logic       hsync, vsync;

    vga_out #(
        .V_ACTIVE (VA),
        .V_FP     (VFP),
        .V_SYNC   (VSW),
        .V_BP     (VBP)
    ) dut (
        .pix_clk   (pix_clk),
        .reset     (reset),
        .rgb_buf   (rgb_buf),
        .pix_ptr_x (pix_ptr_x),
        .pix_ptr_y (pix_ptr_y),
        .reading   (reading),
        .rgb       (rgb),
        .hsync     (hsync),
        .vsync     (vsync)
    );

    always #20 pix_clk = ~pix_clk;

    int npass = 0;
    int ntot  = 0;

    logic [10:0] q[$];
    int hm, vm, cyc;
    int hs_fall, vs_fall, line_rd, frame_rd;
    bit hs_wdone, vs_wdone, prev_hs, prev_vs, frame_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        assert (got === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic check_reset();
        chk("rst_rgb", 32'(rgb), 0);
        chk("rst_hsync", 32'(hsync), 1);
        chk("rst_vsync", 32'(vsync), 1);
        chk("rst_reading", 32'(reading), 0);
        chk("rst_ptr_x", 32'(pix_ptr_x), 0);
        chk("rst_ptr_y", 32'(pix_ptr_y), 0);
    endtask

    task automatic start();
        hm = 0; vm = 0; cyc = 0;
        q.delete();
        q.push_back({9'd0, 1'b1, 1'b1});
        q.push_back({9'd0, 1'b1, 1'b1});
        hs_fall = -1; vs_fall = -1;
        hs_wdone = 0; vs_wdone = 0;
        prev_hs = 1; prev_vs = 1;
        line_rd = 0; frame_rd = 0; frame_done = 0;
    endtask

    // mode 0: buffer echoes the column, 1: all-ones, 2: random colour
    task automatic run(input int n, input int mode);
        bit win_m, rd_m, hs_m, vs_m;
        int px, py;
        logic [8:0] drv;
        logic [10:0] e;
        for (int i = 0; i < n; i++) begin
            @(negedge pix_clk);
            win_m = (vm < VA) && (hm >= 64) && (hm < 576);
            px    = win_m ? (hm - 64) / 2 : 0;
            py    = (vm < VA) ? vm / 2 : 0;
            rd_m  = win_m && (vm % 2 == 0) && ((hm - 64) % 2 == 0);
            hs_m  = !(hm >= 656 && hm <= 751);
            vs_m  = !(vm >= VSS && vm <= VSE);
            chk("ptr_x", 32'(pix_ptr_x), 32'(px));
            chk("ptr_y", 32'(pix_ptr_y), 32'(py));
            chk("reading", 32'(reading), 32'(rd_m));
            case (mode)
                0:       drv = 9'(px);
                1:       drv = 9'h1FF;
                default: drv = 9'($urandom_range(511));
            endcase
            q.push_back({win_m ? drv : 9'd0, hs_m, vs_m});
            e = q.pop_front();
            chk("rgb", 32'(rgb), 32'(e[10:2]));
            chk("hsync", 32'(hsync), 32'(e[1]));
            chk("vsync", 32'(vsync), 32'(e[0]));
            if (prev_hs && !hsync && hs_fall < 0) begin
                hs_fall = cyc;
                chk("hs_start", 32'(cyc), 658);
            end
            if (!prev_hs && hsync && hs_fall >= 0 && !hs_wdone) begin
                hs_wdone = 1;
                chk("hs_width", 32'(cyc - hs_fall), 96);
            end
            if (prev_vs && !vsync && vs_fall < 0) begin
                vs_fall = cyc;
                chk("vs_start", 32'(cyc), 32'(VSS * HT + 2));
            end
            if (!prev_vs && vsync && vs_fall >= 0 && !vs_wdone) begin
                vs_wdone = 1;
                chk("vs_width", 32'(cyc - vs_fall), 1600);
            end
            prev_hs = hsync;
            prev_vs = vsync;
            if (reading) begin
                line_rd++;
                frame_rd++;
            end
            if (hm == HT - 1) begin
                chk("line_reads", 32'(line_rd),
                    (vm < VA && vm % 2 == 0) ? 32'd256 : 32'd0);
                line_rd = 0;
                if (vm == VT - 1 && !frame_done) begin
                    frame_done = 1;
                    chk("frame_reads", 32'(frame_rd), 32'((VA / 2) * 256));
                end
            end
            @(posedge pix_clk);
            #1 rgb_buf = drv;
            hm++;
            if (hm == HT) begin
                hm = 0;
                vm = (vm == VT - 1) ? 0 : vm + 1;
            end
            cyc++;
        end
    endtask

    initial begin
        reset   = 1'b0;
        rgb_buf = 9'h1FF;
        repeat (3) @(negedge pix_clk);
        check_reset();
        @(posedge pix_clk);
        #2 reset = 1'b1;
        start();
        run(5000, 0);
        // async reset in the middle of a line
        @(posedge pix_clk);
        #3 reset = 1'b0;
        #1 check_reset();
        @(negedge pix_clk);
        check_reset();
        @(posedge pix_clk);
        #2 reset = 1'b1;
        start();
        run(VT * HT + 300, 0);
        chk("frame_seen", 32'(frame_done), 1);
        chk("vs_seen", 32'(vs_wdone), 1);
        run(3000, 1);
        run(2000, 2);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/vga_out.md
Name: vga_out

Overview:
- VGA 640x480@60 Hz timing generator and pixel output stage for the NES video path.
- Scans the 256x240 NES picture at 2x scale (512x480), centred horizontally with 64-pixel black borders.
- Issues per-pixel read requests and a scanline-buffer address (pix_ptr_x, pix_ptr_y).
- Accepts the decoded 9-bit colour (rgb_buf) one clock later and drives rgb/hsync/vsync, all aligned to each other.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- H_OFFSET, 64, first visible column of the NES window
- SYNC_ACTIVE, 0, logic level of hsync/vsync during the pulse

Ports:
- pix_clk  in  1  pixel clock, 25.175 MHz nominal; the only clock
- reset  in  1  asynchronous, active-low reset
- rgb_buf  in  9  decoded colour {R[2:0],G[2:0],B[2:0]}, valid one pix_clk after the pix_ptr_x/pix_ptr_y it answers
- pix_ptr_x  out  8  NES column 0..255 being fetched
- pix_ptr_y  out  8  NES row 0..239 being fetched
- reading  out  1  high for one clock = pop the next NES pixel from the FIFO into the scanline buffer
- rgb  out  9  colour to DAC; 0 outside the NES window and during blanking
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync

Behaviour:
- Counters:
  - h runs 0..799, wraps to 0 and increments v.
  - v runs 0..524, wraps to 0 after (h=799, v=524).
  - Visible region is h<640, v<480.
  - hsync pulse region is h in [656,751]; vsync pulse region is v in [490,491].
- NES window: win = v<480 and h in [64,575].
  - Inside win: pix_ptr_x = (h-64)>>1, pix_ptr_y = v>>1.
  - Outside win: pix_ptr_x = 0. pix_ptr_y = 0 when v>=480, otherwise v>>1.
- Read request: reading = win and v[0]==0 and (h-64)[0]==0.
  - Gives exactly 256 pulses per even line and 0 on odd lines.
  - Total 61440 pulses per frame.
  - Odd lines replay the scanline buffer filled on the preceding even line.
- Combinational outputs: pix_ptr_x, pix_ptr_y and reading are combinational decodes of the h/v registers and change only after a pix_clk edge.
- Pipeline (one stage):
  - win, hsync_raw and vsync_raw are registered (win_d, hs_d, vs_d).
  - On each edge: rgb <= win_d ? rgb_buf : 0; hsync <= hs_d; vsync <= vs_d.
  - Latency from counter state to pins is 2 clocks for rgb, hsync and vsync alike, so they stay mutually aligned.
- Reset (async, active-low) forces:
  - h=0, v=0
  - rgb=0
  - hsync=vsync=!SYNC_ACTIVE (inactive)
  - win_d=0
  - reading=0, pix_ptr_x=0, pix_ptr_y=0 (follows from h=0)
- Counting resumes on the first pix_clk edge after reset deasserts.
- Reset mid-frame aborts the frame; the next frame starts at h=0, v=0.
- rgb_buf is ignored, and rgb is forced to 0, whenever win_d=0.
- Widths: h is 10 bits, v is 10 bits. The (h-64)>>1 subtraction is 10-bit; only the low 8 bits drive pix_ptr_x.

Decomposition:
- Package vga_timing_pkg holds the timing constants (H_TOTAL=800, V_TOTAL=525, sync start/end values) and a typedef for the 9-bit rgb9_t.
- Sub-module vga_timing_counter holds the h/v counters and produces the raw visible/hsync/vsync/win decodes.
- vga_out instantiates vga_timing_counter and adds the reading/pointer decode and the output pipeline.

Test Plan:
- Reset with reset=0 mid-line, then release -> rgb=0, hsync=vsync=1, reading=0 during reset; after release h counts from 0, and the first hsync low pulse starts at rgb-aligned clock 658 (656+2) and lasts 96 clocks.
- Run one full frame -> 800 clocks per line, 525 lines; vsync low for exactly 1600 clocks (2 lines), starting at line 490.
- Count reading pulses over a frame -> exactly 61440. On v=0 pulses occur at h=64,66,...,574 with pix_ptr_x=0..255. Line v=1 has none.
- Drive rgb_buf = {1'b0, pix_ptr_x} delayed one clock -> rgb at column 64+2k and 65+2k (pin time) equals k; rgb=0 at columns 0..63 and 576..639.
- Set v=479 and v=480 boundaries -> pix_ptr_y=239 on lines 478/479; reading=0 and rgb=0 for lines 480..524.
- Hold rgb_buf=9'h1FF constantly -> rgb is 9'h1FF only within the window and 0 during horizontal/vertical blanking and borders.
